// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers with per-channel enable and rise ticks.
// Divisor updates are held pending and applied only at a period end, or at once while the channel is halted.
module clk_div_bank #(
    parameter int                NUM_CH      = 2,
    parameter int                CNT_W       = 8,
    parameter int                DEFAULT_DIV = 4,
    parameter logic [NUM_CH-1:0] EN_RST      = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_valid_i,
    input  logic [2:0]        cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic              cfg_ready_o,
    output logic              cfg_err_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  div_reg  [NUM_CH];
    logic [CNT_W-1:0]  pend_div [NUM_CH];
    logic [NUM_CH-1:0] en_reg;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] at_top;
    logic              in_range;

    // Handshake: a write transfers on any edge where cfg_valid_i && cfg_ready_o.
    // Ready only depends on the addressed channel's pending flag; out-of-range
    // targets are always ready so the write drains and raises cfg_err_o.
    always_comb begin
        sel    = '0;
        at_top = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]    = (cfg_ch_i == 3'(i));
            at_top[i] = (cnt[i] == div_reg[i]);
        end
        in_range    = |sel;
        cfg_ready_o = in_range ? ~|(sel & pending_o) : 1'b1;
        accept      = {NUM_CH{cfg_valid_i}} & sel & ~pending_o;
        // A high phase always runs to completion, even after en_i drops.
        run         = en_i | clk_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_o <= 1'b0;
            clk_o     <= '0;
            tick_o    <= '0;
            pending_o <= '0;
            en_reg    <= EN_RST;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                div_reg[i]  <= CNT_W'(DEFAULT_DIV);
                pend_div[i] <= CNT_W'(DEFAULT_DIV);
            end
        end else begin
            cfg_err_o <= cfg_valid_i && !in_range;
            for (int i = 0; i < NUM_CH; i++) begin
                en_reg[i] <= run[i];
                tick_o[i] <= run[i] && at_top[i] && !clk_o[i];
                if (run[i]) begin
                    if (at_top[i]) begin
                        cnt[i]   <= '0;
                        clk_o[i] <= ~clk_o[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
                // Apply reads the registered pending flag, so a write accepted on a
                // boundary edge waits for the next boundary.
                if (accept[i]) begin
                    pend_div[i]  <= cfg_div_i;
                    pending_o[i] <= 1'b1;
                end else if (pending_o[i] &&
                             ((run[i] && at_top[i] && clk_o[i]) || (!en_reg[i] && !run[i]))) begin
                    div_reg[i]   <= pend_div[i];
                    pending_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (NUM_CH=2, DEFAULT_DIV=4); expected values worked out by hand per edge.
module tb_clk_div_bank;

    logic       clk;
    logic       rst;
    logic [1:0] en_i;
    logic       cfg_valid_i;
    logic [2:0] cfg_ch_i;
    logic [7:0] cfg_div_i;
    logic       cfg_ready_o;
    logic       cfg_err_o;
    logic [1:0] pending_o;
    logic [1:0] clk_o;
    logic [1:0] tick_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];

    clk_div_bank dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_err_o  (cfg_err_o),
        .pending_o  (pending_o),
        .clk_o      (clk_o),
        .tick_o     (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en_i = 2'b11; cfg_valid_i = 1'b0; cfg_ch_i = 3'd0; cfg_div_i = 8'd0;
        step(2);
        check("rst_clk", 32'(clk_o), 32'h0);
        check("rst_tick", 32'(tick_o), 32'h0);
        check("rst_pend", 32'(pending_o), 32'h0);
        check("rst_err", 32'(cfg_err_o), 32'h0);
        check("rst_ready", 32'(cfg_ready_o), 32'h1);
        rst = 1'b0;

        // Default D=4: both channels rise on the 5th edge after release
        exp_q = {2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("def_clk_e%0d", k), 32'(clk_o), 32'(exp_q.pop_front()));
            check($sformatf("def_tick_e%0d", k), 32'(tick_o), (k == 5) ? 32'h3 : 32'h0);
        end

        // D=1 to ch0 mid high phase; accepted on edge 7, applied on edge 10
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd0; cfg_div_i = 8'd1; #1;
        check("mid_ready", 32'(cfg_ready_o), 32'h1);
        step(1);
        cfg_valid_i = 1'b0;
        check("mid_pend", 32'(pending_o), 32'h1);
        #1;
        check("mid_stall", 32'(cfg_ready_o), 32'h0);
        step(2);
        check("mid_e9_clk0", 32'(clk_o[0]), 32'h1);
        check("mid_e9_pend", 32'(pending_o), 32'h1);
        step(1);
        check("mid_e10_clk", 32'(clk_o), 32'h0);
        check("mid_e10_pend", 32'(pending_o), 32'h0);
        step(1);
        check("d1_e11_clk0", 32'(clk_o[0]), 32'h0);
        step(1);
        check("d1_e12_clk0", 32'(clk_o[0]), 32'h1);
        check("d1_e12_tick0", 32'(tick_o[0]), 32'h1);

        // Out-of-range write
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd5; cfg_div_i = 8'd7; #1;
        check("oor_ready", 32'(cfg_ready_o), 32'h1);
        step(1);
        cfg_valid_i = 1'b0; cfg_ch_i = 3'd0;
        check("oor_err", 32'(cfg_err_o), 32'h1);
        check("oor_pend", 32'(pending_o), 32'h0);
        check("oor_e13_clk0", 32'(clk_o[0]), 32'h1);
        check("oor_e13_tick0", 32'(tick_o[0]), 32'h0);
        step(1);
        check("oor_err_clr", 32'(cfg_err_o), 32'h0);
        check("oor_e14_clk0", 32'(clk_o[0]), 32'h0);
        step(1);
        check("e15_clk", 32'(clk_o), 32'h2);
        check("e15_tick", 32'(tick_o), 32'h2);
        step(1);
        check("e16_clk", 32'(clk_o), 32'h3);
        check("e16_tick", 32'(tick_o), 32'h1);

        // Drop en_i[1] two cycles into its high phase
        en_i = 2'b01;
        step(3);
        check("halt_e19_clk1", 32'(clk_o[1]), 32'h1);
        step(1);
        check("halt_e20_clk1", 32'(clk_o[1]), 32'h0);
        step(1);
        check("halt_e21_clk1", 32'(clk_o[1]), 32'h0);
        step(1);
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd1; cfg_div_i = 8'd0; #1;
        check("halt_ready", 32'(cfg_ready_o), 32'h1);
        step(1);
        cfg_valid_i = 1'b0; cfg_ch_i = 3'd0;
        check("halt_e23_pend", 32'(pending_o), 32'h2);
        check("halt_e23_clk1", 32'(clk_o[1]), 32'h0);
        step(1);
        check("halt_e24_pend", 32'(pending_o), 32'h0);
        check("halt_e24_clk1", 32'(clk_o[1]), 32'h0);
        step(1);
        en_i = 2'b11;
        step(1);
        check("res_e26_clk", 32'(clk_o), 32'h2);
        check("res_e26_tick1", 32'(tick_o[1]), 32'h1);
        step(1);
        check("res_e27_clk1", 32'(clk_o[1]), 32'h0);
        check("res_e27_tick1", 32'(tick_o[1]), 32'h0);
        step(1);
        check("res_e28_clk", 32'(clk_o), 32'h3);
        check("res_e28_tick", 32'(tick_o), 32'h3);

        // Reset mid-period with a pending write on ch0
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd0; cfg_div_i = 8'd6;
        step(1);
        cfg_valid_i = 1'b0;
        check("rst2_pre_pend", 32'(pending_o), 32'h1);
        rst = 1'b1;
        step(1);
        check("rst2_clk", 32'(clk_o), 32'h0);
        check("rst2_tick", 32'(tick_o), 32'h0);
        check("rst2_pend", 32'(pending_o), 32'h0);
        check("rst2_err", 32'(cfg_err_o), 32'h0);
        check("rst2_ready", 32'(cfg_ready_o), 32'h1);
        rst = 1'b0;

        // Write on the exact 1->0 boundary of ch0 (edge 10 after release)
        step(4);
        check("bnd_e4_clk", 32'(clk_o), 32'h0);
        step(1);
        check("bnd_e5_clk", 32'(clk_o), 32'h3);
        check("bnd_e5_tick", 32'(tick_o), 32'h3);
        step(4);
        check("bnd_e9_clk0", 32'(clk_o[0]), 32'h1);
        cfg_valid_i = 1'b1; cfg_ch_i = 3'd0; cfg_div_i = 8'd2; #1;
        check("bnd_ready", 32'(cfg_ready_o), 32'h1);
        step(1);
        check("bnd_e10_clk", 32'(clk_o), 32'h0);
        check("bnd_e10_pend", 32'(pending_o), 32'h1);
        cfg_div_i = 8'd3; #1;
        check("bnd_stall", 32'(cfg_ready_o), 32'h0);
        step(1);
        cfg_valid_i = 1'b0;
        check("bnd_e11_pend", 32'(pending_o), 32'h1);
        step(3);
        check("bnd_e14_clk0", 32'(clk_o[0]), 32'h0);
        step(1);
        check("bnd_e15_clk0", 32'(clk_o[0]), 32'h1);
        step(4);
        check("bnd_e19_clk0", 32'(clk_o[0]), 32'h1);
        check("bnd_e19_pend", 32'(pending_o), 32'h1);
        step(1);
        check("bnd_e20_clk0", 32'(clk_o[0]), 32'h0);
        check("bnd_e20_pend", 32'(pending_o), 32'h0);
        step(2);
        check("bnd_e22_clk0", 32'(clk_o[0]), 32'h0);
        step(1);
        check("bnd_e23_clk0", 32'(clk_o[0]), 32'h1);
        check("bnd_e23_tick0", 32'(tick_o[0]), 32'h1);
        step(2);
        check("bnd_e25_clk", 32'(clk_o), 32'h3);
        step(1);
        check("bnd_e26_clk0", 32'(clk_o[0]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
